// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the two-master SRAM arbiter: source IDs, FSM states and
// default widths.
package sram_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int MAX_OUT_DEF    = 2;
  localparam int STARVE_LIM_DEF = 4;
  localparam int STRB_W         = 4;

  // Source IDs stored in the response-routing FIFO.
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_fifo.sv
// Small circular FIFO holding the source ID of every accepted transaction so
// in-order responses can be steered back to the master that issued them.
module sram_arb_fifo
  import sram_arbiter_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pops on an empty FIFO are stale responses and are dropped here.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is carried
  // by the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one SRAM-like bridge port with
// grant locking, an outstanding-transaction limit and in-order response routing.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_OUT    = MAX_OUT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  // fetch master
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // load/store master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // bridge
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);

  arb_state_e state_q, state_d;
  logic [2:0] starve_q, starve_d;
  logic       req_raw, sel_data, accept, pop;
  logic       fifo_full, fifo_empty, fifo_head;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    sel_data = 1'b0;
    req_raw  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Data wins unless fetch has waited through STARVE_LIM data grants.
        sel_data = data_req && !(inst_req && starve_q == STARVE_MAX);
        req_raw  = !fifo_full && (inst_req || data_req);
        if (req_raw && !mem_addr_ok) state_d = sel_data ? ARB_LOCK_D : ARB_LOCK_I;
      end
      ARB_LOCK_I: begin
        req_raw = 1'b1;
        if (mem_addr_ok) state_d = ARB_IDLE;
      end
      ARB_LOCK_D: begin
        sel_data = 1'b1;
        req_raw  = 1'b1;
        if (mem_addr_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request path is combinational, so it is qualified by reset to keep the
  // bridge quiet while rstn is low.
  assign mem_req   = req_raw && rstn;
  assign mem_wr    = sel_data && data_wr;
  assign mem_wstrb = sel_data ? data_wstrb : '0;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;
  assign mem_wdata = sel_data ? data_wdata : '0;

  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && !sel_data;
  assign data_addr_ok = accept && sel_data;

  assign pop          = mem_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (fifo_head == SRC_INST);
  assign data_data_ok = pop && (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    starve_d = starve_q;
    if (!inst_req || inst_addr_ok) begin
      starve_d = '0;
    end else if (data_addr_ok && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  sram_arb_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (1)
  ) u_src_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (accept),
    .push_data_i (sel_data ? SRC_DATA : SRC_INST),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic, checked cycle by cycle against a queue-based reference model.
module tb_sram_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_OUT    = 2;
  localparam int STARVE_LIM = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              inst_req, inst_addr_ok, inst_data_ok;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata, data_rdata;
  logic              mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, which masters are waiting for responses
  // (oldest first), and how many data grants fetch has sat through.
  bit src_q[$];      // 0 = fetch, 1 = load/store
  int owner;         // 0 = nobody locked, 1 = fetch, 2 = load/store
  int starve;
  bit inst_taken, data_taken;

  task automatic model_reset();
    src_q.delete();
    owner      = 0;
    starve     = 0;
    inst_taken = 1'b0;
    data_taken = 1'b0;
  endtask

  // Inputs are already set (posedge+1); check at the falling edge, then advance.
  task automatic cycle();
    int grant;
    bit acc, pop, head;
    @(negedge clk);
    if (owner != 0)                                           grant = owner;
    else if (src_q.size() >= MAX_OUT)                         grant = 0;
    else if (data_req && !(inst_req && starve == STARVE_LIM)) grant = 2;
    else if (inst_req)                                        grant = 1;
    else                                                      grant = 0;
    acc  = (grant != 0) && mem_addr_ok;
    pop  = mem_data_ok && (src_q.size() != 0);
    head = pop ? src_q[0] : 1'b0;

    check("mem_req", mem_req, grant != 0);
    if (grant == 1) begin
      check("inst_mem_addr",  mem_addr,  inst_addr);
      check("inst_mem_wr",    mem_wr,    0);
      check("inst_mem_wstrb", mem_wstrb, 0);
      check("inst_mem_wdata", mem_wdata, 0);
    end else if (grant == 2) begin
      check("data_mem_addr",  mem_addr,  data_addr);
      check("data_mem_wr",    mem_wr,    data_wr);
      check("data_mem_wstrb", mem_wstrb, data_wstrb);
      check("data_mem_wdata", mem_wdata, data_wdata);
    end
    check("inst_addr_ok", inst_addr_ok, acc && grant == 1);
    check("data_addr_ok", data_addr_ok, acc && grant == 2);
    check("inst_data_ok", inst_data_ok, pop && !head);
    check("data_data_ok", data_data_ok, pop && head);
    if (pop && head)  check("data_rdata", data_rdata, mem_rdata);
    if (pop && !head) check("inst_rdata", inst_rdata, mem_rdata);

    if (pop) src_q.delete(0);
    if (acc) src_q.push_back(grant == 2);
    owner = (grant != 0 && !acc) ? grant : 0;
    if (!inst_req || (acc && grant == 1)) starve = 0;
    else if (acc && grant == 2 && starve < STARVE_LIM) starve++;
    inst_taken = acc && grant == 1;
    data_taken = acc && grant == 2;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_req    = 1'b0; inst_addr  = '0;
    data_req    = 1'b0; data_wr    = 1'b0; data_wstrb = '0;
    data_addr   = '0;   data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic drain();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    for (int i = 0; i < MAX_OUT + 1; i++) begin
      mem_data_ok = 1'b1;
      mem_rdata   = $urandom;
      cycle();
    end
    mem_data_ok = 1'b0;
  endtask

  initial begin
    model_reset();
    quiet();
    rstn = 1'b0;
    // Requests and bridge handshakes active during reset must not leak out.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #3;
    check("rst_mem_req",      mem_req,      0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    check("rst_inst_data_ok", inst_data_ok, 0);
    check("rst_data_data_ok", data_data_ok, 0);
    repeat (2) @(posedge clk);
    #1;
    quiet();
    rstn = 1'b1;

    // Lone fetch accepted immediately, answered next cycle.
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
    cycle();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000;
    #1;
    check("s1_inst_rdata", inst_rdata, 32'h0280_0000);
    cycle();
    mem_data_ok = 1'b0;

    // Simultaneous requests: write goes first, fetch next, responses in order.
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_1000;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'hF; mem_addr_ok = 1'b1;
    #1;
    check("s2_mem_wr", mem_wr, 1);
    cycle();
    data_req = 1'b0;
    cycle();
    drain();

    // Data locked on the bus while the bridge stalls; fetch waits.
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000; data_wstrb = 4'h0;
    mem_addr_ok = 1'b0;
    cycle();
    inst_req = 1'b1; inst_addr = 32'h1C00_0008;
    cycle();
    cycle();
    #1;
    check("s3_lock_addr", mem_addr, 32'h0000_2000);
    mem_addr_ok = 1'b1;
    cycle();
    data_req = 1'b0;
    cycle();
    drain();

    // Outstanding limit: two accepted, third held off until a response frees a slot.
    inst_req = 1'b1; inst_addr = 32'h1C00_0010; mem_addr_ok = 1'b1;
    cycle();
    inst_addr = 32'h1C00_0014;
    cycle();
    inst_addr = 32'h1C00_0018;
    cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    cycle();
    mem_rdata = 32'h2222_2222;
    cycle();
    mem_data_ok = 1'b0; inst_addr = 32'h1C00_001C;
    cycle();
    inst_addr = 32'h1C00_0020;
    cycle();
    drain();

    // Starvation: four data grants, then fetch is forced through.
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = $urandom;
      cycle();
      if (inst_taken) inst_addr = inst_addr + 32'd4;
      if (data_taken) data_addr = data_addr + 32'd4;
    end
    drain();

    // Reset in the middle of a locked fetch with one response outstanding.
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_4000;
    data_wdata = 32'h0BAD_F00D; data_wstrb = 4'h3; mem_addr_ok = 1'b1;
    cycle();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0200; mem_addr_ok = 1'b0;
    cycle();
    cycle();
    rstn = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #2;
    check("midrst_mem_req",      mem_req,      0);
    check("midrst_inst_addr_ok", inst_addr_ok, 0);
    check("midrst_data_addr_ok", data_addr_ok, 0);
    check("midrst_inst_data_ok", inst_data_ok, 0);
    check("midrst_data_data_ok", data_data_ok, 0);
    model_reset();
    @(posedge clk);
    #1;
    quiet();
    rstn = 1'b1;
    mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_0000;
    cycle();
    mem_data_ok = 1'b0;

    // Randomized traffic; masters hold each request until it is accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!inst_req || inst_taken) begin
        inst_req  = 1'($urandom_range(0, 1));
        inst_addr = $urandom;
      end
      if (!data_req || data_taken) begin
        data_req   = 1'($urandom_range(0, 1));
        data_wr    = 1'($urandom_range(0, 1));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata   = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
